// File: rtl/rv64g_l1_vec_bank_sched.sv
// Vector-lane request queue for one L1 bank: replays the head until the
// arbiter grants it, tags responses, and raises a scalar hold-off on starvation.
module rv64g_l1_vec_bank_sched #(
   parameter int INDEX_W      = 5,
   parameter int DEPTH        = 4,
   parameter int ID_W         = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   enq_valid_i,
   output logic                   enq_ready_o,
   input  logic                   enq_we_i,
   input  logic [INDEX_W-1:0]     enq_index_i,
   input  logic [2:0]             enq_word_i,
   input  logic [2:0]             enq_way_i,
   input  logic [7:0]             enq_be_i,
   input  logic [63:0]            enq_wdata_i,
   input  logic [ID_W-1:0]        enq_id_i,
   output logic                   vec_req_o,
   output logic                   vec_we_o,
   output logic [INDEX_W-1:0]     vec_index_o,
   output logic [2:0]             vec_word_o,
   output logic [2:0]             vec_way_o,
   output logic [7:0]             vec_be_o,
   output logic [63:0]            vec_wdata_o,
   input  logic                   vec_stall_i,
   input  logic [63:0]            bank_rdata_i,
   output logic                   rsp_valid_o,
   output logic [ID_W-1:0]        rsp_id_o,
   output logic                   rsp_we_o,
   output logic [63:0]            rsp_rdata_o,
   output logic                   scalar_hold_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int STALL_W = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic               we;
      logic [INDEX_W-1:0] index;
      logic [2:0]         word;
      logic [2:0]         way;
      logic [7:0]         be;
      logic [63:0]        wdata;
      logic [ID_W-1:0]    id;
   } entry_t;

   typedef enum logic [1:0] {IDLE, ISSUE, STARVED} state_t;

   entry_t             mem [DEPTH];
   entry_t             head;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [STALL_W-1:0] stall_cnt;
   logic [STALL_W-1:0] stall_cnt_nxt;
   state_t             state;
   state_t             state_nxt;
   logic               hold;
   logic               rsp_valid;
   logic               rsp_we;
   logic [ID_W-1:0]    rsp_id;
   logic               empty;
   logic               full;
   logic               push;
   logic               grant;
   logic               last;

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));
   assign head  = mem[rd_ptr];

   assign enq_ready_o = !full && !flush_i;
   assign push        = enq_valid_i && enq_ready_o;
   assign vec_req_o   = !empty && !flush_i;
   assign grant       = vec_req_o && !vec_stall_i;
   assign last        = (count == CNT_W'(1)) && !push;

   assign vec_we_o    = head.we;
   assign vec_index_o = head.index;
   assign vec_word_o  = head.word;
   assign vec_way_o   = head.way;
   assign vec_be_o    = head.be;
   assign vec_wdata_o = head.wdata;

   assign rsp_valid_o   = rsp_valid;
   assign rsp_id_o      = rsp_id;
   assign rsp_we_o      = rsp_we;
   assign rsp_rdata_o   = (rsp_valid && !rsp_we) ? bank_rdata_i : 64'd0;
   assign scalar_hold_o = hold;
   assign count_o       = count;

   // Entry storage needs no reset: occupancy gates every read.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem[wr_ptr] <= '{we: enq_we_i, index: enq_index_i,
                          word: enq_word_i, way: enq_way_i,
                          be: enq_be_i, wdata: enq_wdata_i,
                          id: enq_id_i};
      end
   end

   always_comb begin
      stall_cnt_nxt = stall_cnt;
      if (flush_i || grant || empty) begin
         stall_cnt_nxt = '0;
      end else if (vec_stall_i && stall_cnt != STALL_W'(STARVE_LIMIT)) begin
         stall_cnt_nxt = stall_cnt + STALL_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      if (flush_i) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE: if (push) state_nxt = ISSUE;
            ISSUE: begin
               if (grant && last) state_nxt = IDLE;
               else if (stall_cnt_nxt == STALL_W'(STARVE_LIMIT)) state_nxt = STARVED;
            end
            STARVED: if (grant) state_nxt = last ? IDLE : ISSUE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         stall_cnt <= '0;
         state     <= IDLE;
         hold      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_we    <= 1'b0;
         rsp_id    <= '0;
      end else begin
         stall_cnt <= stall_cnt_nxt;
         state     <= state_nxt;
         hold      <= (state_nxt == STARVED);
         rsp_valid <= grant;
         if (grant) begin
            rsp_id <= head.id;
            rsp_we <= head.we;
         end
         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (grant) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !grant) count <= count + CNT_W'(1);
            else if (grant && !push) count <= count - CNT_W'(1);
         end
      end
   end

endmodule
